mips_exec_core: RTL and testbench

- Execute/writeback core of the single-issue MIPS lab CPU: instruction decoder, 32x32 register file, ALU, HI/LO registers and GPIO port in one block.
- Fetch logic outside the block presents one 32-bit instruction per cycle on `instr`.
- The block decodes and executes that instruction combinationally, then retires its register result through a one-cycle writeback register.

---
 rtl/mips_exec_core.sv | 188 ++++++++++++++++++
 tb/tb_mips_exec_core.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_core.sv
// Execute/writeback core of the single-issue MIPS lab CPU: decode, 32x32 regfile, ALU, HI/LO, GPIO.
// Optional macro WB_BYPASS_EN forwards the writeback register into EX operands.
module mips_exec_core #(
   parameter logic [31:0] GPIO_RST_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP0  = 6'h10;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   logic [31:0] rf_q [32];
   logic [31:0] hi_q, lo_q, gpio_q;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] simm, zimm;
   logic [31:0] rs_rf, rt_rf, rs_val, rt_val;
   logic        hilo_we, gpio_we;
   logic [63:0] prod;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];
   assign simm  = {{16{imm[15]}}, imm};
   assign zimm  = {16'h0000, imm};

   assign rs_rf = (rs == 5'd0) ? 32'h0 : rf_q[rs];
   assign rt_rf = (rt == 5'd0) ? 32'h0 : rf_q[rt];

`ifdef WB_BYPASS_EN
   // Writeback result is not yet in the regfile during the next EX cycle; forward it.
   assign rs_val = (wb_valid_q && wb_addr_q != 5'd0 && wb_addr_q == rs) ? wb_data_q : rs_rf;
   assign rt_val = (wb_valid_q && wb_addr_q != 5'd0 && wb_addr_q == rt) ? wb_data_q : rt_rf;
`else
   assign rs_val = rs_rf;
   assign rt_val = rt_rf;
`endif

   always_comb begin
      wb_valid_d = 1'b0;
      wb_addr_d  = rd;
      wb_data_d  = 32'h0;
      hilo_we    = 1'b0;
      prod       = 64'h0;
      gpio_we    = 1'b0;
      case (op)
         OP_RTYPE: begin
            wb_valid_d = 1'b1;
            case (funct)
               F_ADD, F_ADDU: wb_data_d = rs_val + rt_val;
               F_SUB, F_SUBU: wb_data_d = rs_val - rt_val;
               F_AND:         wb_data_d = rs_val & rt_val;
               F_OR:          wb_data_d = rs_val | rt_val;
               F_XOR:         wb_data_d = rs_val ^ rt_val;
               F_NOR:         wb_data_d = ~(rs_val | rt_val);
               F_SLL:         wb_data_d = rt_val << shamt;
               F_SRL:         wb_data_d = rt_val >> shamt;
               F_SRA:         wb_data_d = $signed(rt_val) >>> shamt;
               F_SLT:         wb_data_d = {31'h0, $signed(rs_val) < $signed(rt_val)};
               F_SLTU:        wb_data_d = {31'h0, rs_val < rt_val};
               F_MFHI:        wb_data_d = hi_q;
               F_MFLO:        wb_data_d = lo_q;
               F_MULT: begin
                  // Low 64 bits of the sign-extended product equal the signed product.
                  wb_valid_d = 1'b0;
                  hilo_we    = 1'b1;
                  prod       = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
               end
               F_MULTU: begin
                  wb_valid_d = 1'b0;
                  hilo_we    = 1'b1;
                  prod       = {32'h0, rs_val} * {32'h0, rt_val};
               end
               default:       wb_valid_d = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = rs_val + simm;
         end
         OP_SLTI: begin
            wb_valid_d = 1'b1; wb_addr_d = rt;
            wb_data_d  = {31'h0, $signed(rs_val) < $signed(simm)};
         end
         OP_SLTIU: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = {31'h0, rs_val < simm};
         end
         OP_ANDI: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = rs_val & zimm;
         end
         OP_ORI: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = rs_val | zimm;
         end
         OP_XORI: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = rs_val ^ zimm;
         end
         OP_LUI: begin
            wb_valid_d = 1'b1; wb_addr_d = rt; wb_data_d = {imm, 16'h0000};
         end
         OP_COP0: begin
            wb_addr_d = rt;
            if (rs == 5'b00100) begin
               gpio_we = 1'b1;
            end else if (rs == 5'b00000) begin
               wb_valid_d = 1'b1;
               wb_data_d  = gpio_in;
            end
         end
         default: wb_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_q <= 1'b0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= 32'h0;
         hi_q       <= 32'h0;
         lo_q       <= 32'h0;
         gpio_q     <= GPIO_RST_VAL;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         if (hilo_we) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
         end
         if (gpio_we) gpio_q <= rt_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      end else if (wb_valid_q && wb_addr_q != 5'd0) begin
         rf_q[wb_addr_q] <= wb_data_q;
      end
   end

   assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : rf_q[dbg_addr];
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign gpio_out = gpio_q;

endmodule

// File: tb/tb_mips_exec_core.sv
// Bench for mips_exec_core: directed vector table, hand sequences for timing/reset, random vs. reference model.
module tb_mips_exec_core;

   localparam logic [31:0] RST_GPIO = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = 32'h0;
   logic [31:0] gpio_in = 32'h0;
   logic [31:0] gpio_out;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data;
   logic [31:0] hi_out, lo_out;

   int checks = 0;
   int failures = 0;

   mips_exec_core #(.GPIO_RST_VAL(RST_GPIO)) dut (
      .clk(clk), .rst(rst), .instr(instr), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] r_ins(input logic [4:0] rs_f, rt_f, rd_f, sh_f, input logic [5:0] fn);
      return {6'h00, rs_f, rt_f, rd_f, sh_f, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op_f, input logic [4:0] rs_f, rt_f, input logic [15:0] im);
      return {op_f, rs_f, rt_f, im};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Issue one instruction for one cycle; returns 1ns after the capturing edge.
   task automatic step(input logic [31:0] ins);
      instr = ins;
      @(posedge clk);
      #1;
      instr = 32'h0;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_rf [32];
   logic [31:0] m_hi, m_lo, m_gpio;
   logic        p_v;
   logic [4:0]  p_a;
   logic [31:0] p_d;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_gpio = RST_GPIO;
      p_v = 1'b0; p_a = 5'd0; p_d = 32'h0;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (p_v && p_a == r) return p_d;
`endif
      return m_rf[r];
   endfunction

   // Architectural effect of one instruction, then the clock edge it retires on.
   task automatic model_step(input logic [31:0] ins, input logic [31:0] gin);
      logic [31:0] a, b, res;
      logic        we, hl_we, g_we;
      logic [4:0]  dst;
      logic [15:0] im;
      int          sa, sb, si;
      shortint     sim;
      longint      ps;
      longint unsigned pu;
      logic [63:0] p64;
      a = model_read(ins[25:21]);
      b = model_read(ins[20:16]);
      sa = a; sb = b;
      im = ins[15:0];
      sim = im; si = sim;
      res = 32'h0; we = 1'b0; hl_we = 1'b0; g_we = 1'b0; p64 = 64'h0;
      dst = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
      case (ins[31:26])
         6'h00: begin
            we = 1'b1;
            case (ins[5:0])
               6'h20, 6'h21: res = a + b;
               6'h22, 6'h23: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b);
               6'h00: res = b << ins[10:6];
               6'h02: res = b >> ins[10:6];
               6'h03: res = sb >>> ins[10:6];
               6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
               6'h2B: res = (a < b) ? 32'd1 : 32'd0;
               6'h10: res = m_hi;
               6'h12: res = m_lo;
               6'h18: begin
                  we = 1'b0; hl_we = 1'b1;
                  ps = longint'(sa) * longint'(sb);
                  p64 = ps;
               end
               6'h19: begin
                  we = 1'b0; hl_we = 1'b1;
                  pu = longint'(a) * longint'(b);
                  p64 = pu;
               end
               default: we = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin we = 1'b1; res = a + si; end
         6'h0A: begin we = 1'b1; res = (sa < si) ? 32'd1 : 32'd0; end
         6'h0B: begin we = 1'b1; res = (a < 32'(si)) ? 32'd1 : 32'd0; end
         6'h0C: begin we = 1'b1; res = a & 32'(im); end
         6'h0D: begin we = 1'b1; res = a | 32'(im); end
         6'h0E: begin we = 1'b1; res = a ^ 32'(im); end
         6'h0F: begin we = 1'b1; res = 32'(im) * 32'd65536; end
         6'h10: begin
            if (ins[25:21] == 5'd4) g_we = 1'b1;
            else if (ins[25:21] == 5'd0) begin we = 1'b1; res = gin; end
         end
         default: ;
      endcase
      // clock edge
      if (p_v && p_a != 5'd0) m_rf[p_a] = p_d;
      p_v = we; p_a = dst; p_d = res;
      if (hl_we) begin m_hi = p64[63:32]; m_lo = p64[31:0]; end
      if (g_we) m_gpio = b;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] ins;
      int          sel;   // 0 = register, 1 = HI, 2 = LO, 3 = gpio_out
      logic [4:0]  addr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [31:0] ins, input int sel, input logic [4:0] addr, input logic [31:0] exp);
      vec_t v;
      v.ins = ins; v.sel = sel; v.addr = addr; v.exp = exp;
      vecs.push_back(v);
   endtask

   logic [5:0] r_fn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h10, 6'h12};
   logic [5:0] i_op [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
   logic [5:0] bad_op [4] = '{6'h3F, 6'h23, 6'h2B, 6'h04};

   initial begin
      logic [31:0] d, ins, act;
      logic [4:0]  ra;
      int          k;

      add_vec(i_ins(6'h08, 0, 1, 16'h7FFF), 0, 1, 32'h0000_7FFF);
      add_vec(i_ins(6'h08, 0, 2, 16'hFFFF), 0, 2, 32'hFFFF_FFFF);
      add_vec(r_ins(1, 2, 3, 0, 6'h20),     0, 3, 32'h0000_7FFE);
      add_vec(r_ins(0, 1, 4, 0, 6'h22),     0, 4, 32'hFFFF_8001);
      add_vec(r_ins(1, 2, 5, 0, 6'h2B),     0, 5, 32'h0000_0001);
      add_vec(r_ins(1, 2, 6, 0, 6'h2A),     0, 6, 32'h0000_0000);
      add_vec(i_ins(6'h0F, 0, 1, 16'h8000), 0, 1, 32'h8000_0000);
      add_vec(r_ins(0, 1, 2, 4, 6'h03),     0, 2, 32'hF800_0000);
      add_vec(r_ins(0, 1, 3, 4, 6'h02),     0, 3, 32'h0800_0000);
      add_vec(i_ins(6'h0D, 1, 4, 16'h1234), 0, 4, 32'h8000_1234);
      add_vec(r_ins(0, 0, 5, 0, 6'h27),     0, 5, 32'hFFFF_FFFF);
      add_vec(r_ins(1, 0, 6, 4, 6'h00),     0, 6, 32'h0000_0000);
      add_vec(i_ins(6'h08, 0, 1, 16'hFFFF), 0, 1, 32'hFFFF_FFFF);
      add_vec(i_ins(6'h08, 0, 2, 16'h0002), 0, 2, 32'h0000_0002);
      add_vec(r_ins(1, 2, 0, 0, 6'h18),     1, 0, 32'hFFFF_FFFF);
      add_vec(32'h0,                        2, 0, 32'hFFFF_FFFE);
      add_vec(r_ins(1, 2, 0, 0, 6'h19),     1, 0, 32'h0000_0001);
      add_vec(32'h0,                        2, 0, 32'hFFFF_FFFE);
      add_vec(r_ins(0, 0, 8, 0, 6'h12),     0, 8, 32'hFFFF_FFFE);
      add_vec(i_ins(6'h10, 0, 7, 16'h0),    0, 7, 32'hA5A5_0F0F);
      add_vec(i_ins(6'h10, 4, 7, 16'h0),    3, 0, 32'hA5A5_0F0F);
      add_vec(i_ins(6'h08, 0, 0, 16'h0009), 0, 0, 32'h0000_0000);
      add_vec(i_ins(6'h3F, 0, 8, 16'h0001), 0, 8, 32'hFFFF_FFFE);

      // power-on reset
      repeat (3) @(posedge clk);
      #1;
      chk("por_hi", hi_out, 32'h0);
      chk("por_lo", lo_out, 32'h0);
      chk("por_gpio", gpio_out, RST_GPIO);
      read_reg(5'd5, d);
      chk("por_r5", d, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // directed table, one NOP after each instruction
      gpio_in = 32'hA5A5_0F0F;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].ins);
         step(32'h0);
         case (vecs[i].sel)
            1: act = hi_out;
            2: act = lo_out;
            3: act = gpio_out;
            default: read_reg(vecs[i].addr, act);
         endcase
         chk($sformatf("vec%0d", i), act, vecs[i].exp);
      end

      // mfhi directly after mult sees the new HI
      step(r_ins(1, 2, 0, 0, 6'h18));
      step(r_ins(0, 0, 3, 0, 6'h10));
      step(32'h0);
      step(32'h0);
      read_reg(5'd3, d);
      chk("mfhi_after_mult", d, 32'hFFFF_FFFF);

      // MTC0 visible after a single edge
      step(i_ins(6'h10, 4, 3, 16'h0));
      chk("mtc0_one_edge", gpio_out, 32'hFFFF_FFFF);

      // debug port shows the regfile only, never the writeback register
      step(i_ins(6'h08, 0, 9, 16'h0055));
      read_reg(5'd9, d);
      chk("dbg_no_bypass", d, 32'h0);
      step(32'h0);
      read_reg(5'd9, d);
      chk("dbg_after_wb", d, 32'h0000_0055);

      // asynchronous reset mid-run
      rst = 1'b0;
      #1;
      for (int r = 0; r < 32; r++) begin
         read_reg(5'(r), d);
         chk($sformatf("rst_r%0d", r), d, 32'h0);
      end
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_gpio", gpio_out, RST_GPIO);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back dependency
      step(i_ins(6'h08, 0, 1, 16'd5));
      step(i_ins(6'h08, 1, 2, 16'd1));
      step(32'h0);
      step(32'h0);
      read_reg(5'd1, d);
      chk("hazard_r1", d, 32'd5);
      read_reg(5'd2, d);
`ifdef WB_BYPASS_EN
      chk("hazard_r2", d, 32'd6);
`else
      chk("hazard_r2", d, 32'd1);
`endif

      // randomized run against the model
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 500; n++) begin
         k = $urandom_range(0, 9);
         if (k <= 3)
            ins = r_ins(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)), r_fn[$urandom_range(0, 16)]);
         else if (k <= 6)
            ins = i_ins(i_op[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        16'($urandom));
         else if (k == 7)
            ins = i_ins(6'h10, ($urandom_range(0, 3) == 0) ? 5'd1 : (($urandom_range(0, 1) == 1) ? 5'd4 : 5'd0),
                        5'($urandom_range(0, 7)), 16'($urandom));
         else if (k == 8)
            ins = ($urandom_range(0, 1) == 1) ?
                  i_ins(bad_op[$urandom_range(0, 3)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)) :
                  r_ins(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 5'd0, 6'h3F);
         else
            ins = 32'h0;
         gpio_in = $urandom;
         model_step(ins, gpio_in);
         step(ins);
         chk($sformatf("rnd%0d_hi", n), hi_out, m_hi);
         chk($sformatf("rnd%0d_lo", n), lo_out, m_lo);
         chk($sformatf("rnd%0d_gpio", n), gpio_out, m_gpio);
         ra = 5'($urandom_range(0, 7));
         read_reg(ra, d);
         chk($sformatf("rnd%0d_r%0d", n, ra), d, m_rf[ra]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
